// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing and VGA output stage. Free-running horizontal/vertical
//   counters feed a registered decode stage that drives the pattern
//   generator. The decode flags are then delayed by LATENCY cycles so that
//   sync and blank line up with the generator's RGB in a final output
//   register.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing, pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing, lines
//   HS_POL/VS_POL              asserted level of vga_hs / vga_vs
//   LATENCY                    pixel_enable -> valid RGB cycles, legal range 0..4
//   Each total (active+porches+sync) must be <= 1024.
//
// Ports
//   clk                   pixel clock, rising edge
//   rst_n                 asynchronous active-low reset
//   red_in/green_in/blue_in  pixel colour from the pattern generator
//   pixel_enable          high for each active pixel slot
//   x, y                  coordinates of the current slot
//   frame_start           one-cycle pulse on slot (0,0)
//   vga_r/vga_g/vga_b     colour to the DAC, 0 while blanked
//   vga_hs/vga_vs         sync outputs
//   vga_blank_n           high during visible pixels
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned LATENCY  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic       pixel_enable,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    // Region bounds are compared at 11 bits so an active width of 1024 still works.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Flag bundle carried down the delay line: {active, hsync, vsync}
    localparam int unsigned F_ACT = 2;
    localparam int unsigned F_HS  = 1;
    localparam int unsigned F_VS  = 0;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_act;
    logic       v_act;
    logic       h_syn;
    logic       v_syn;
    logic       hs_flag;
    logic       vs_flag;
    logic [2:0] flags_dec;
    logic [2:0] flags_dly;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_comb begin
        h_act = ({1'b0, h_cnt} < H_ACT_END);
        v_act = ({1'b0, v_cnt} < V_ACT_END);
        h_syn = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
        v_syn = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
    end

    // ------------------------------------------------------------------
    // Decode stage: one cycle behind the counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_enable <= 1'b0;
            x            <= '0;
            y            <= '0;
            frame_start  <= 1'b0;
            hs_flag      <= 1'b0;
            vs_flag      <= 1'b0;
        end else begin
            pixel_enable <= h_act && v_act;
            x            <= h_cnt;
            y            <= v_cnt;
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            hs_flag      <= h_syn;
            vs_flag      <= v_syn;
        end
    end

    assign flags_dec = {pixel_enable, hs_flag, vs_flag};

    // ------------------------------------------------------------------
    // Flag delay line matching the generator's RGB latency
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign flags_dly = flags_dec;
        end else begin : g_delay
            logic [2:0] sr [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < LATENCY; i++) begin
                        sr[i] <= '0;
                    end
                end else begin
                    sr[0] <= flags_dec;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign flags_dly = sr[LATENCY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register: colour, sync and blank for the same slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
        end else begin
            vga_r       <= flags_dly[F_ACT] ? red_in   : '0;
            vga_g       <= flags_dly[F_ACT] ? green_in : '0;
            vga_b       <= flags_dly[F_ACT] ? blue_in  : '0;
            vga_blank_n <= flags_dly[F_ACT];
            vga_hs      <= flags_dly[F_HS] ? HS_POL : ~HS_POL;
            vga_vs      <= flags_dly[F_VS] ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-timing instance (LATENCY=1) ----------------
    logic [7:0] red_in  = 8'hFF;
    logic [7:0] green_in = 8'hFF;
    logic [7:0] blue_in = 8'hFF;
    logic       pixel_enable, frame_start;
    logic [9:0] x, y;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pixel_enable(pixel_enable), .x(x), .y(y), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    // Registered behavioural pattern generator, one cycle of latency.
    always @(posedge clk) begin
        if (pixel_enable) begin
            red_in  <= x[7:0];
            blue_in <= y[7:0];
        end
    end

    // ---------------- small raster instance (LATENCY=0) ----------------
    logic [7:0] s_red, s_green, s_blue;
    logic       s_pe, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_r, s_g, s_b;
    logic       s_hs, s_vs, s_bl;

    assign s_red   = s_x[7:0];
    assign s_green = 8'h3C;
    assign s_blue  = s_y[7:0];

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .LATENCY(0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n),
        .red_in(s_red), .green_in(s_green), .blue_in(s_blue),
        .pixel_enable(s_pe), .x(s_x), .y(s_y), .frame_start(s_fs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_bl)
    );

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       bl;
        logic       hs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, logic pe, int xx, int yy, logic fs,
                                logic bl, logic hs, int r, int g, int b);
        vec_t v;
        v.n = n; v.pe = pe; v.x = 10'(xx); v.y = 10'(yy); v.fs = fs;
        v.bl = bl; v.hs = hs; v.r = 8'(r); v.g = 8'(g); v.b = 8'(b);
        return v;
    endfunction

    initial begin
        int ti;
        int pe_hi, hs_lo, first_bl;
        int s_hs_lo, s_vs_lo, s_frames, s_last_fs;
        int s, h, v, so, ho, vo;
        logic act_o;

        // Cycle n = state after the n-th rising edge following reset release.
        // Decode shows counter slot n-1; outputs show slot n-3 (LATENCY=1).
        //          n    pe x    y  fs bl hs r     g     b
        tbl.push_back(mk(1,   1, 0,   0, 1, 0, 1, 0,    0,    0));
        tbl.push_back(mk(2,   1, 1,   0, 0, 0, 1, 0,    0,    0));
        tbl.push_back(mk(3,   1, 2,   0, 0, 1, 1, 8'h00, 8'hFF, 0));
        tbl.push_back(mk(4,   1, 3,   0, 0, 1, 1, 8'h01, 8'hFF, 0));
        tbl.push_back(mk(640, 1, 639, 0, 0, 1, 1, 8'h7D, 8'hFF, 0));
        tbl.push_back(mk(641, 0, 640, 0, 0, 1, 1, 8'h7E, 8'hFF, 0));
        tbl.push_back(mk(642, 0, 641, 0, 0, 1, 1, 8'h7F, 8'hFF, 0));
        tbl.push_back(mk(643, 0, 642, 0, 0, 0, 1, 0,    0,    0));
        tbl.push_back(mk(658, 0, 657, 0, 0, 0, 1, 0,    0,    0));
        tbl.push_back(mk(659, 0, 658, 0, 0, 0, 0, 0,    0,    0));
        tbl.push_back(mk(754, 0, 753, 0, 0, 0, 0, 0,    0,    0));
        tbl.push_back(mk(755, 0, 754, 0, 0, 0, 1, 0,    0,    0));
        tbl.push_back(mk(800, 0, 799, 0, 0, 0, 1, 0,    0,    0));
        tbl.push_back(mk(801, 1, 0,   1, 0, 0, 1, 0,    0,    0));
        tbl.push_back(mk(803, 1, 2,   1, 0, 1, 1, 8'h00, 8'hFF, 1));
        tbl.push_back(mk(810, 1, 9,   1, 0, 1, 1, 8'h07, 8'hFF, 1));

        // ---- reset held with clock running ----
        repeat (3) @(posedge clk);
        #1;
        chk("reset_default", 64'({pixel_enable, x, y, frame_start, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}),
            64'({1'b0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0}));
        chk("reset_small", 64'({s_pe, s_x, s_y, s_fs, s_r, s_g, s_b, s_hs, s_vs, s_bl}),
            64'({1'b0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0}));

        @(negedge clk);
        rst_n = 1'b1;

        ti = 0; pe_hi = 0; hs_lo = 0; first_bl = -1;
        s_hs_lo = 0; s_vs_lo = 0; s_frames = 0; s_last_fs = -1;

        for (int n = 1; n <= 810; n++) begin
            @(posedge clk);
            #1;

            // default instance: table vectors
            if (ti < tbl.size() && tbl[ti].n == n) begin
                chk($sformatf("line_vec_n%0d", n),
                    64'({pixel_enable, x, y, frame_start, vga_blank_n, vga_hs, vga_r, vga_g, vga_b}),
                    64'({tbl[ti].pe, tbl[ti].x, tbl[ti].y, tbl[ti].fs, tbl[ti].bl, tbl[ti].hs,
                         tbl[ti].r, tbl[ti].g, tbl[ti].b}));
                ti++;
            end
            if (n <= 800 && pixel_enable) pe_hi++;
            if (!vga_hs) hs_lo++;
            if (vga_blank_n && first_bl < 0) first_bl = n;
            if (!vga_blank_n)
                chk($sformatf("blank_rgb_n%0d", n), 64'({vga_r, vga_g, vga_b}), 64'(0));

            // small instance: arithmetic raster model, 3 frames plus one edge
            if (n <= 106) begin
                s = n - 1;
                h = s % 7;
                v = (s / 7) % 5;
                chk($sformatf("small_dec_n%0d", n), 64'({s_pe, s_x, s_y, s_fs}),
                    64'({(h < 4 && v < 2), 10'(h), 10'(v), (h == 0 && v == 0)}));
                if (n >= 2) begin
                    so = n - 2;
                    ho = so % 7;
                    vo = (so / 7) % 5;
                    act_o = (ho < 4 && vo < 2);
                    chk($sformatf("small_out_n%0d", n), 64'({s_bl, s_hs, s_vs, s_r, s_g, s_b}),
                        64'({act_o, (ho != 5), (vo != 3),
                             act_o ? 8'(ho) : 8'h00, act_o ? 8'h3C : 8'h00, act_o ? 8'(vo) : 8'h00}));
                    if (!s_hs) s_hs_lo++;
                    if (!s_vs) s_vs_lo++;
                end
                if (s_fs) begin
                    if (s_last_fs >= 0)
                        chk($sformatf("small_fs_period_n%0d", n), 64'(n - s_last_fs), 64'(35));
                    s_last_fs = n;
                    s_frames++;
                end
            end
        end

        chk("table_consumed", 64'(ti), 64'(tbl.size()));
        chk("pe_high_first_line", 64'(pe_hi), 64'(640));
        chk("hs_low_cycles", 64'(hs_lo), 64'(96));
        chk("first_blank_n_rise", 64'(first_bl), 64'(3));
        chk("small_frame_pulses", 64'(s_frames), 64'(4));
        chk("small_hs_low", 64'(s_hs_lo), 64'(15));
        chk("small_vs_low", 64'(s_vs_lo), 64'(21));

        // ---- asynchronous reset mid-line (default is in active video here) ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_default", 64'({pixel_enable, x, y, frame_start, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}),
            64'({1'b0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0}));
        chk("async_reset_small", 64'({s_pe, s_x, s_y, s_fs, s_r, s_g, s_b, s_hs, s_vs, s_bl}),
            64'({1'b0, 10'd0, 10'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0}));
        @(posedge clk);
        #1;
        chk("reset_held_default", 64'({pixel_enable, vga_blank_n, vga_r}), 64'(0));

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_default", 64'({pixel_enable, x, y, frame_start, vga_blank_n}),
            64'({1'b1, 10'd0, 10'd0, 1'b1, 1'b0}));
        chk("restart_small", 64'({s_pe, s_x, s_y, s_fs, s_bl}),
            64'({1'b1, 10'd0, 10'd0, 1'b1, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing and output stage for the pixel pipeline. It generates the horizontal and vertical counters and drives `pixel_enable` and pixel coordinates into the pattern generator. It captures the generator's registered RGB and drives the VGA pins with RGB, sync and blank aligned to the same pixel. The default timing is 640x480@60 with `clk` as the 25.175 MHz pixel clock.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, pixels
- `H_SYNC`, default 96: hsync width, pixels
- `H_BP`, default 48: horizontal back porch, pixels
- `V_ACTIVE`, default 480: visible lines
- `V_FP`, default 10: vertical front porch, lines
- `V_SYNC`, default 2: vsync width, lines
- `V_BP`, default 33: vertical back porch, lines
- `HS_POL`, default 0: asserted level of `vga_hs`
- `VS_POL`, default 0: asserted level of `vga_vs`
- `LATENCY`, default 1: cycles from `pixel_enable` to valid `red_in/green_in/blue_in`; legal range 0..4
- `clk`  in  1  pixel clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `red_in`, `green_in`, `blue_in`  in  8 each  pixel colour from the pattern generator
- `pixel_enable`  out  1  high for each active pixel slot; drives the generator `enable`
- `x`, `y`  out  10 each  coordinates of the current slot; valid while `pixel_enable`=1
- `frame_start`  out  1  one-cycle pulse on slot (0,0)
- `vga_r`, `vga_g`, `vga_b`  out  8 each  colour to the DAC
- `vga_hs`, `vga_vs`  out  1 each  sync outputs
- `vga_blank_n`  out  1  high during visible pixels

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤ 1024.
- `h_cnt` counts 0..H_TOTAL-1 and increments every cycle; it wraps to 0 after H_TOTAL-1.
- `v_cnt` increments when `h_cnt` wraps; it wraps to 0 when `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1 together.
- Active region: `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- hsync region: H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync region: V_ACTIVE+V_FP ≤ `v_cnt` < V_ACTIVE+V_FP+V_SYNC (default lines 490..491). The whole line is in vsync, not aligned to hsync.
- Decode stage (registered): from the current counters it produces `pixel_enable` (= active), `x`=`h_cnt`, `y`=`v_cnt` and `frame_start` (=`h_cnt`==0 and `v_cnt`==0).
- The active, hsync and vsync flags from the decode stage go through a LATENCY-deep shift register. The RGB is then captured in a final output register along with them.
- Output register:
  - `vga_r/g/b` = RGB input if the delayed active flag is 1, else 0.
  - `vga_blank_n` = delayed active flag.
  - `vga_hs` = HS_POL when the delayed hsync flag is set, else ~HS_POL; `vga_vs` likewise with VS_POL.
- Reset values: counters 0; `pixel_enable`, `x`, `y`, `frame_start`, `vga_r/g/b`, `vga_blank_n` all 0; `vga_hs`=~HS_POL; `vga_vs`=~VS_POL; all delay-line flags cleared.
- Reset mid-frame: all outputs go to their reset values immediately, with no clock needed. The raster restarts at (0,0) with no partial-frame recovery.
- RGB inputs are ignored outside delayed-active slots. Blanked output is always 0.

## Timing
- Cycle E is the cycle where `pixel_enable`=1 for pixel (x,y).
- The RGB input for that pixel is sampled at cycle E+LATENCY.
- `vga_r/g/b`, `vga_blank_n`, `vga_hs` and `vga_vs` for that slot appear at cycle E+LATENCY+1. Sync and blank are therefore exactly aligned with the colour.
- The counters lead the decode outputs by 1 cycle.
- At the first rising edge after `rst_n` releases, `pixel_enable`=1, `x`=0, `y`=0 and `frame_start`=1.
- `pixel_enable` is high for exactly H_ACTIVE consecutive cycles per active line. Defaults:
  - Low for 160 cycles between active lines.
  - Low for 45 full lines (36000 cycles) in vertical blanking.
- `frame_start` period: H_TOTAL*V_TOTAL cycles (default 420000).
- `vga_hs` is asserted for H_SYNC cycles per line. `vga_vs` is asserted for V_SYNC*H_TOTAL cycles per frame.

## Test plan
- Reset check: hold `rst_n`=0 and toggle `clk`. Outputs read: r/g/b=0, blank_n=0, hs=1, vs=1, pixel_enable=0. Asserting `rst_n` asynchronously mid-line clears all outputs before the next edge.
- Line timing, defaults: after reset release, `pixel_enable` is high for 640 cycles then low for 160. `vga_hs` goes low at output slot 656 for 96 cycles. `vga_blank_n` rises LATENCY+1 cycles after `pixel_enable`.
- Frame timing: consecutive `frame_start` pulses are 420000 cycles apart. `vga_vs` is low for 1600 cycles starting at output line 490. `y` reaches 524, then returns to 0.
- Alignment, LATENCY=1: a behavioural generator drives `red_in`={x[7:0]} and `blue_in`={y[7:0]} one cycle after `pixel_enable`. Each `vga_r` value seen with `vga_blank_n`=1 equals that slot's x[7:0], with the first visible pixel 0x00.
- Blanking: hold RGB inputs at 0xFF continuously. `vga_r/g/b`=0 whenever `vga_blank_n`=0, including front/back porch and sync.
- Small raster: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, LATENCY=0. Frame period is 35 cycles, and h/v wrap-around is correct for 3 frames.
